// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator.
// The operands are captured on start and compared MSB first, one bit pair
// per clock. The comparison stops at the first bit pair that differs.
// State table:
//   IDLE  | waiting for start; results from the last comparison are held
//   SHIFT | comparing one bit pair per cycle, MSB first
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [WIDTH-1:0]               a_in,
    input  logic [WIDTH-1:0]               b_in,
    output logic                           busy,
    output logic                           done,
    output logic                           g,
    output logic                           e,
    output logic                           l,
    output logic [$clog2(WIDTH+1)-1:0]     bits_used
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              g_q, g_d;
    logic              e_q, e_d;
    logic              l_q, l_d;
    logic [CW-1:0]     used_q, used_d;

    // Register all state; reset leaves an "equal" result with nothing examined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b1;
            l_q     <= 1'b0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            used_q  <= used_d;
        end
    end

    // Next-state logic: capture on start, then compare/shift until a decision.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        used_d  = used_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = WIDTH_C;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q << 1;
                b_d   = b_q << 1;
                cnt_d = cnt_q - ONE_C;
                if (a_q[WIDTH-1] != b_q[WIDTH-1]) begin
                    // Pairs examined so far = WIDTH - remaining + 1.
                    g_d     = a_q[WIDTH-1];
                    e_d     = 1'b0;
                    l_d     = b_q[WIDTH-1];
                    used_d  = WIDTH_C - cnt_q + ONE_C;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == ONE_C) begin
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    used_d  = WIDTH_C;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign g         = g_q;
    assign e         = e_q;
    assign l         = l_q;
    assign bits_used = used_q;

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width in bits; legal range 2..32.
REQ-002 Port clk SHALL be input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be input, width 1, the reset; reset is synchronous and active-low.
REQ-004 Port start SHALL be input, width 1, a request to load operands and begin a comparison.
REQ-005 Port a_in SHALL be input, width WIDTH, operand A, unsigned.
REQ-006 Port b_in SHALL be input, width WIDTH, operand B, unsigned.
REQ-007 Port busy SHALL be output, width 1, high while a comparison is in progress.
REQ-008 Port done SHALL be output, width 1, a one-cycle pulse marking a valid result.
REQ-009 Port g SHALL be output, width 1, the registered A>B result.
REQ-010 Port e SHALL be output, width 1, the registered A==B result.
REQ-011 Port l SHALL be output, width 1, the registered A<B result.
REQ-012 Port bits_used SHALL be output, width $clog2(WIDTH+1), the count of bit pairs examined for the last result.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 In IDLE with start=1 at an edge: capture a_in/b_in into internal shift registers, load the remaining-bit counter with WIDTH, and move to SHIFT; busy=1 from that edge.
REQ-015 In IDLE with start=0: hold all state and outputs.
REQ-016 In SHIFT, each edge SHALL compare the MSBs of both shift registers (one-bit compare), then shift both left by one and decrement the counter.
REQ-017 On the first differing bit pair: set g=1,e=0,l=0 if A bit=1, else g=0,e=0,l=1; pulse done; go to IDLE (early termination).
REQ-018 If the last pair (counter=1) is equal with no prior difference: set g=0,e=1,l=0; pulse done; go to IDLE.
REQ-019 Latency: with start sampled at edge T and first difference at bit position WIDTH-1-k (k=0 for MSB), done SHALL be high for the cycle after edge T+1+k; equal operands give done after edge T+WIDTH.
REQ-020 bits_used SHALL update together with g/e/l to k+1 (difference) or WIDTH (equal).
REQ-021 Exactly one of g/e/l SHALL be high once a result exists; g/e/l/bits_used SHALL hold until the next result.
REQ-022 done SHALL be high for exactly one cycle per comparison, and busy SHALL be low in that cycle.
REQ-023 start SHALL be ignored while in SHIFT; a_in/b_in changes after capture SHALL not affect the running comparison.
REQ-024 start=1 in the done cycle SHALL be accepted (state is IDLE), giving back-to-back operation.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, g=0, e=1, l=0, bits_used=0, clear shift registers and counter, overriding start.
REQ-026 Reset asserted during SHIFT SHALL abort the comparison with no done pulse; outputs take reset values.

Verification
REQ-027 WIDTH=8, A=8'h80, B=8'h7F, start at edge T -> done after edge T+1, g=1,e=0,l=0, bits_used=1.
REQ-028 A=8'h3C, B=8'h3C -> busy for 8 cycles, done after edge T+8, e=1, bits_used=8.
REQ-029 A=8'h12, B=8'h13 -> done after edge T+8, l=1, bits_used=8.
REQ-030 A=8'h40,B=8'h00 then start held high in done cycle with A=8'h00,B=8'h01 -> second done follows with no idle cycle between comparisons, results g then l.
REQ-031 Mid-SHIFT: toggle start and change a_in/b_in -> result unchanged; assert rst_n=0 mid-SHIFT -> no done, e=1, busy=0 next cycle.
REQ-032 Random A/B, 1000 comparisons -> g/e/l match reference compare, bits_used matches first-difference index.
